phase_error_detector: RTL

PHASE_ERROR_DETECTOR -- requirements
Module: phase_error_detector

---
 rtl/adpll_pkg.sv | 21 ++
 rtl/edge_sync.sv | 32 +++
 rtl/phase_error_detector.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/adpll_pkg.sv
// Shared definitions for the ADPLL phase detector: pairing FSM encoding and
// saturation limits of the measurement counters.
package adpll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_OUT = 2'd1,
        ST_WAIT_IN  = 2'd2
    } pair_state_t;

    // Largest positive value of a w-bit signed phase error.
    function automatic int phase_sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Largest value of a w-bit unsigned period count.
    function automatic int period_sat_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for an asynchronous input followed by a registered
// rising-edge detector producing a one-cycle pulse.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;
    logic                   prev_reg;

    // hist/prev form the edge history; the pulse lands SYNC_STAGES+1 cycles
    // after the first sampling edge, and reset clears history so no stale edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg   <= '0;
            hist_reg   <= 1'b0;
            prev_reg   <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            sync_reg   <= {sync_reg[SYNC_STAGES-2:0], async_in};
            hist_reg   <= sync_reg[SYNC_STAGES-1];
            prev_reg   <= hist_reg;
            edge_pulse <= hist_reg & ~prev_reg;
        end
    end

endmodule

// File: rtl/phase_error_detector.sv
// Phase/frequency detector: pairs reference and feedback edges, measures the
// signed phase error and reference period, and tracks lock / cycle slips.
module phase_error_detector
    import adpll_pkg::*;
#(
    parameter int CNT_W       = 12,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_WIN    = 2,
    parameter int LOCK_CNT    = 4
) (
    input  logic                    MainClock,
    input  logic                    ResetN,
    input  logic                    InputSignal,
    input  logic                    OutputSignal,
    output logic                    InputSignalEdge,
    output logic                    OutputSignalEdge,
    output logic                    Lead,
    output logic                    Lag,
    output logic signed [CNT_W-1:0] PhaseError,
    output logic                    ErrValid,
    output logic        [CNT_W-1:0] PeriodCount,
    output logic                    PeriodValid,
    output logic                    Lock,
    output logic                    Slip
);

    localparam logic [CNT_W-1:0] PH_MAX  = CNT_W'(phase_sat_max(CNT_W));
    localparam logic [CNT_W-1:0] PER_MAX = CNT_W'(period_sat_max(CNT_W));
    localparam logic signed [CNT_W-1:0] WIN_POS = CNT_W'(LOCK_WIN);
    localparam logic signed [CNT_W-1:0] WIN_NEG = -WIN_POS;
    localparam int LC_W = $clog2(LOCK_CNT + 1);
    localparam logic [LC_W-1:0] LC_MAX = LC_W'(LOCK_CNT);

    logic [1:0] raw_in;
    logic [1:0] edge_det;
    logic       ie;
    logic       oe;

    assign raw_in = {OutputSignal, InputSignal};

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        edge_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk       (MainClock),
            .rst_n     (ResetN),
            .async_in  (raw_in[gi]),
            .edge_pulse(edge_det[gi])
        );
    end

    assign ie               = edge_det[0];
    assign oe               = edge_det[1];
    assign InputSignalEdge  = ie;
    assign OutputSignalEdge = oe;

    pair_state_t             state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next, cnt_inc, mag;
    logic                    lead_next, lag_next, ev_next, slip_next;
    logic signed [CNT_W-1:0] err_next;

    assign cnt_inc = (cnt_reg == PH_MAX) ? PH_MAX : cnt_reg + 1'b1;
    // Counter holds edges-apart minus one, so the reported magnitude is +1.
    assign mag     = (cnt_reg == PH_MAX) ? PH_MAX : cnt_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        lead_next  = 1'b0;
        lag_next   = 1'b0;
        ev_next    = 1'b0;
        slip_next  = 1'b0;
        err_next   = PhaseError;
        case (state_reg)
            ST_IDLE: begin
                if (ie && oe) begin
                    ev_next  = 1'b1;
                    err_next = '0;
                end else if (ie) begin
                    state_next = ST_WAIT_OUT;
                    cnt_next   = '0;
                end else if (oe) begin
                    state_next = ST_WAIT_IN;
                    cnt_next   = '0;
                end
            end
            ST_WAIT_OUT: begin
                cnt_next = cnt_inc;
                if (oe) begin
                    lag_next   = 1'b1;
                    ev_next    = 1'b1;
                    err_next   = $signed(mag);
                    state_next = ie ? ST_WAIT_IN : ST_IDLE;
                    cnt_next   = '0;
                end else if (ie) begin
                    slip_next = 1'b1;
                    cnt_next  = '0;
                end
            end
            ST_WAIT_IN: begin
                cnt_next = cnt_inc;
                if (ie) begin
                    lead_next  = 1'b1;
                    ev_next    = 1'b1;
                    err_next   = -$signed(mag);
                    state_next = oe ? ST_WAIT_OUT : ST_IDLE;
                    cnt_next   = '0;
                end else if (oe) begin
                    slip_next = 1'b1;
                    cnt_next  = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge MainClock or negedge ResetN) begin
        if (!ResetN) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            Lead       <= 1'b0;
            Lag        <= 1'b0;
            ErrValid   <= 1'b0;
            Slip       <= 1'b0;
            PhaseError <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            Lead       <= lead_next;
            Lag        <= lag_next;
            ErrValid   <= ev_next;
            Slip       <= slip_next;
            PhaseError <= err_next;
        end
    end

    logic [CNT_W-1:0] per_cnt_reg, per_inc;
    logic             seen_reg;

    assign per_inc = (per_cnt_reg == PER_MAX) ? PER_MAX : per_cnt_reg + 1'b1;

    // The first reference edge only arms the period measurement.
    always_ff @(posedge MainClock or negedge ResetN) begin
        if (!ResetN) begin
            per_cnt_reg <= '0;
            seen_reg    <= 1'b0;
            PeriodCount <= '0;
            PeriodValid <= 1'b0;
        end else begin
            PeriodValid <= 1'b0;
            if (ie) begin
                per_cnt_reg <= '0;
                seen_reg    <= 1'b1;
                if (seen_reg) begin
                    PeriodCount <= per_inc;
                    PeriodValid <= 1'b1;
                end
            end else begin
                per_cnt_reg <= per_inc;
            end
        end
    end

    logic [LC_W-1:0] lock_cnt_reg, lock_cnt_next;
    logic            in_win;

    assign in_win = (PhaseError <= WIN_POS) && (PhaseError >= WIN_NEG);

    always_comb begin
        lock_cnt_next = lock_cnt_reg;
        if (Slip) begin
            lock_cnt_next = '0;
        end else if (ErrValid) begin
            if (!in_win)
                lock_cnt_next = '0;
            else if (lock_cnt_reg != LC_MAX)
                lock_cnt_next = lock_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge MainClock or negedge ResetN) begin
        if (!ResetN) begin
            lock_cnt_reg <= '0;
            Lock         <= 1'b0;
        end else begin
            lock_cnt_reg <= lock_cnt_next;
            Lock         <= (lock_cnt_next == LC_MAX);
        end
    end

endmodule
